// File: rtl/register_sb.sv
// register_sb: register file with hardware clear sequencer and pending-write scoreboard (optional REGISTER_SB_BYPASS_EN forwarding)
module register_sb #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   write_reg,
    input  logic [ADDR_W-1:0] reg_addr1,
    input  logic [ADDR_W-1:0] reg_addr2,
    output logic [XLEN-1:0]   rd1,
    output logic [XLEN-1:0]   rd2,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              busy1,
    output logic              busy2,
    output logic              init_busy
);
    localparam int NREGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);
    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;
    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [XLEN-1:0]   rf [NREGS];
    logic [NREGS-1:0]  pending, pending_nxt;
    logic              run, wr_en, iss_en, fwd1, fwd2;
    assign run       = !rst && state == S_RUN;
    assign wr_en     = run && reg_write && addr != '0;
    assign iss_en    = run && issue_valid && issue_rd != '0;
    assign init_busy = !run;
`ifdef REGISTER_SB_BYPASS_EN
    assign fwd1 = wr_en && addr == reg_addr1;
    assign fwd2 = wr_en && addr == reg_addr2;
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif
    assign rd1   = (!run || reg_addr1 == '0) ? '0 : fwd1 ? write_reg : rf[reg_addr1];
    assign rd2   = (!run || reg_addr2 == '0) ? '0 : fwd2 ? write_reg : rf[reg_addr2];
    assign busy1 = run && (fwd1 ? (iss_en && issue_rd == reg_addr1) : pending[reg_addr1]);
    assign busy2 = run && (fwd2 ? (iss_en && issue_rd == reg_addr2) : pending[reg_addr2]);
    // clear sequencer: walk x1..x(NREGS-1) once after reset, then run
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_CLEAR;
            ptr   <= ADDR_W'(1);
        end else if (state == S_CLEAR) begin
            ptr   <= (ptr == LAST) ? ptr : ptr + ADDR_W'(1);
            state <= (ptr == LAST) ? S_RUN : S_CLEAR;
        end
    end
    // storage: zeroed by the sequencer, written by writeback in run
    always_ff @(posedge clk) begin
        if (!rst && state == S_CLEAR)
            rf[ptr] <= '0;
        else if (wr_en)
            rf[addr] <= write_reg;
    end
    // a new issue to a register outranks the retiring write of its older producer
    always_comb begin
        pending_nxt = pending;
        if (wr_en)
            pending_nxt[addr] = 1'b0;
        if (iss_en)
            pending_nxt[issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end
    // scoreboard state
    always_ff @(posedge clk) begin
        if (rst)
            pending <= '0;
        else
            pending <= pending_nxt;
    end
endmodule

// File: tb/tb_register_sb.sv
// tb_register_sb: randomized scoreboard bench for register_sb
module tb_register_sb;
    localparam int NREGS = 32;
`ifdef REGISTER_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b1, reg_write = 1'b0, issue_valid = 1'b0;
    logic [4:0]  addr = '0, reg_addr1 = '0, reg_addr2 = '0, issue_rd = '0;
    logic [31:0] write_reg = '0, rd1, rd2;
    logic        busy1, busy2, init_busy;
    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        b1;
        logic        b2;
        logic        ib;
    } exp_t;
    exp_t        q[$];
    logic [31:0] rf_m [NREGS];
    bit          pend_m [NREGS];
    int          clear_left = 0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    register_sb #(.XLEN(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .reg_write(reg_write), .addr(addr), .write_reg(write_reg),
        .reg_addr1(reg_addr1), .reg_addr2(reg_addr2), .rd1(rd1), .rd2(rd2),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .busy1(busy1), .busy2(busy2), .init_busy(init_busy)
    );

    function automatic logic [31:0] m_rd(bit clr, logic [4:0] a, bit we, logic [4:0] wa, logic [31:0] wd);
        if (clr || a == 0) return 32'h0;
        if (BYP && we && wa == a) return wd;
        return rf_m[a];
    endfunction

    function automatic bit m_busy(bit clr, logic [4:0] a, bit we, logic [4:0] wa, bit iv, logic [4:0] ird);
        if (clr || a == 0) return 1'b0;
        if (BYP && we && wa == a) return iv && ird == a;
        return pend_m[a];
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // one clock cycle of stimulus; expected outputs queued, model advanced across the edge
    task automatic cyc(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input bit iv, input logic [4:0] ird);
        exp_t e;
        bit clr;
        rst = r; reg_write = we; addr = wa; write_reg = wd;
        reg_addr1 = a1; reg_addr2 = a2; issue_valid = iv; issue_rd = ird;
        clr = r || clear_left > 0;
        e.ib  = clr;
        e.rd1 = m_rd(clr, a1, we, wa, wd);
        e.rd2 = m_rd(clr, a2, we, wa, wd);
        e.b1  = m_busy(clr, a1, we, wa, iv, ird);
        e.b2  = m_busy(clr, a2, we, wa, iv, ird);
        q.push_back(e);
        if (r) begin
            foreach (rf_m[i]) rf_m[i] = '0;
            foreach (pend_m[i]) pend_m[i] = 1'b0;
            clear_left = NREGS - 1;
        end else if (clear_left > 0) begin
            clear_left--;
        end else begin
            if (we && wa != 0) begin
                rf_m[wa] = wd;
                pend_m[wa] = 1'b0;
            end
            if (iv && ird != 0) pend_m[ird] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        cyc(0, 0, 5'd0, 32'h0, a1, a2, 0, 5'd0);
    endtask

    // monitor: compare DUT outputs mid-cycle against the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("init_busy", {31'h0, init_busy}, {31'h0, e.ib});
            chk("rd1", rd1, e.rd1);
            chk("rd2", rd2, e.rd2);
            chk("busy1", {31'h0, busy1}, {31'h0, e.b1});
            chk("busy2", {31'h0, busy2}, {31'h0, e.b2});
        end
    end

    initial begin
        logic [4:0] wa, a1, a2, ird;
        foreach (rf_m[i]) rf_m[i] = '0;
        @(posedge clk);
        #1;
        cyc(1, 0, 5'd0, 32'h0, 5'd5, 5'd0, 0, 5'd0);
        cyc(1, 0, 5'd0, 32'h0, 5'd5, 5'd0, 0, 5'd0);
        repeat (31) idle(5'd5, 5'd0);
        cyc(0, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 0, 5'd0);
        idle(5'd5, 5'd5);
        cyc(1, 0, 5'd0, 32'h0, 5'd5, 5'd0, 0, 5'd0);
        repeat (31) idle(5'd5, 5'd0);
        idle(5'd5, 5'd5);
        cyc(0, 1, 5'd7, 32'h1234_5678, 5'd7, 5'd0, 0, 5'd0);
        cyc(0, 1, 5'd0, 32'hFFFF_FFFF, 5'd7, 5'd0, 0, 5'd0);
        idle(5'd7, 5'd0);
        cyc(0, 0, 5'd0, 32'h0, 5'd9, 5'd0, 1, 5'd9);
        idle(5'd9, 5'd0);
        cyc(0, 1, 5'd9, 32'h1, 5'd9, 5'd0, 0, 5'd0);
        idle(5'd9, 5'd0);
        cyc(0, 0, 5'd0, 32'h0, 5'd9, 5'd0, 1, 5'd9);
        cyc(0, 1, 5'd9, 32'h2, 5'd9, 5'd9, 1, 5'd9);
        idle(5'd9, 5'd9);
        cyc(0, 1, 5'd3, 32'hA5A5_A5A5, 5'd0, 5'd3, 0, 5'd0);
        idle(5'd0, 5'd3);
        cyc(0, 1, 5'd4, 32'h7, 5'd4, 5'd0, 0, 5'd0);
        cyc(0, 0, 5'd0, 32'h0, 5'd4, 5'd0, 1, 5'd4);
        idle(5'd4, 5'd4);
        cyc(1, 0, 5'd0, 32'h0, 5'd4, 5'd4, 0, 5'd0);
        repeat (3) cyc(0, 1, 5'd6, 32'd55, 5'd6, 5'd4, 1, 5'd6);
        repeat (28) idle(5'd4, 5'd6);
        idle(5'd4, 5'd6);
        repeat (3000) begin
            wa  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
            a1  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
            a2  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
            ird = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, wa, $urandom,
                a1, a2, $urandom_range(0, 2) == 0, ird);
        end
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/register_sb.md
Name: register_sb

Overview:
- Parametrised successor of the single-cycle register file, for the pipelined core.
- Provides two combinational read ports and one synchronous write port; x0 is hardwired to zero.
- Adds synchronous reset with a hardware clear sequencer.
- Adds a per-register pending scoreboard so decode can detect RAW hazards against in-flight writebacks.
- Sits between decode (read/issue) and writeback (write).

Parameters:
- XLEN, 32, data width of each register.
- ADDR_W, 5, register address width; register count NREGS = 2**ADDR_W (derived localparam).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- reg_write  input  1  writeback enable.
- addr  input  ADDR_W  writeback destination register.
- write_reg  input  XLEN  writeback data.
- reg_addr1  input  ADDR_W  read port 1 address.
- reg_addr2  input  ADDR_W  read port 2 address.
- rd1  output  XLEN  read port 1 data (combinational).
- rd2  output  XLEN  read port 2 data (combinational).
- issue_valid  input  1  an instruction with a destination is issued this cycle.
- issue_rd  input  ADDR_W  destination of the issued instruction.
- busy1  output  1  reg_addr1 has a pending (unwritten) result.
- busy2  output  1  reg_addr2 has a pending result.
- init_busy  output  1  clear sequencer active; pipeline must stall.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - rst=1 at a rising edge: state<=CLEAR, clear pointer<=1, all pending bits<=0.
  - rst overrides every other input in that cycle.
  - Reset asserted mid-CLEAR or mid-RUN restarts CLEAR from pointer 1.
- Outputs while in CLEAR, including the reset cycle:
  - init_busy=1.
  - rd1=rd2=0.
  - busy1=busy2=0.
- CLEAR state:
  - Each cycle writes 0 to rf[pointer], then pointer++.
  - When the pointer equals NREGS-1, that register is cleared and state<=RUN the same edge.
  - CLEAR therefore lasts exactly NREGS-1 cycles after rst deasserts; default is 31.
  - reg_write and issue_valid are ignored in CLEAR.
- RUN state (init_busy=0):
  - Write: reg_write=1 and addr!=0 → rf[addr]<=write_reg at the edge.
  - Writes to addr=0 are dropped.
  - Read: rdN = (reg_addrN==0) ? 0 : rf[reg_addrN].
  - Without bypass, a read of a register being written in the same cycle returns the old value.
- Scoreboard (RUN only):
  - issue_valid=1 and issue_rd!=0 → pending[issue_rd]<=1.
  - reg_write=1 and addr!=0 → pending[addr]<=0.
  - Same cycle, same register, issue and write together: set wins (the write retires the older producer; the new issue remains pending).
  - Different registers in the same cycle: both updates apply.
  - pending[0] is constant 0.
  - busyN = pending[reg_addrN] (combinational, registered state).
  - Writes to registers that are not pending are legal and leave pending=0.
- Width rules:
  - No arithmetic on data.
  - Pointer is ADDR_W bits and never wraps; CLEAR exits at NREGS-1.

Optional Feature:
- Macro: REGISTER_SB_BYPASS_EN.
- Defined — write-to-read forwarding applies in RUN when reg_write=1, addr!=0 and addr==reg_addrN:
  - rdN=write_reg in the same cycle.
  - busyN=0 unless issue_valid=1 with issue_rd==reg_addrN in the same cycle, in which case busyN=1.
- Not defined:
  - rdN returns the stored (old) value.
  - busyN reflects the registered pending bit only.
- No effect in CLEAR.

Test Plan:
- Reset clear: preload rf[5]=32'hDEAD_BEEF, pulse rst 1 cycle → init_busy=1 for exactly 31 cycles, rd1=0 throughout; after CLEAR, reading x5 returns 0.
- Write/read and x0: write 32'h1234_5678 to x7, then 32'hFFFF_FFFF to x0; read x7 → 32'h1234_5678, read x0 → 0.
- Scoreboard:
  - Issue rd=9 → busy1=1 for reg_addr1=9 from the next cycle.
  - Writeback to x9 → busy1=0 after that edge.
  - Issue rd=9 and write x9 in the same cycle → busy1 remains 1.
- Same-cycle read of write (x3 ← 32'hA5A5_A5A5, old value 0):
  - Without the macro → rd2=0, then 32'hA5A5_A5A5 next cycle.
  - With REGISTER_SB_BYPASS_EN → rd2=32'hA5A5_A5A5 in the same cycle.
- Reset mid-RUN: pending[4]=1, x4=7, assert rst → busy=0 and init_busy=1 next cycle; after 31 cycles x4=0.
- Ignored ops in CLEAR: reg_write x6=55 and issue rd=6 during CLEAR → after RUN, x6=0 and busy=0.
